// File: rtl/tx_frame_buffer_pp.sv
// Ping-pong frame store: the writer fills one bank by address while the other bank
// streams out in address order on a valid/ready interface with backpressure.
module tx_frame_buffer_pp #(
    parameter int DATA_WIDTH     = 8,
    parameter int TOTAL_PIXELS   = 42240,
    parameter int ADDR_WIDTH     = $clog2(TOTAL_PIXELS),
    parameter int DROP_CNT_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      we,
    input  logic [DATA_WIDTH-1:0]     wData,
    input  logic [ADDR_WIDTH-1:0]     wAddr,
    input  logic                      frame_tick,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [DATA_WIDTH-1:0]     m_data,
    output logic                      m_last,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      frame_drop,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt,
    output logic                      wr_bank
);

    typedef enum logic [1:0] {IDLE, PRIME, STREAM} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TOTAL_PIXELS - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH     = (ADDR_WIDTH + 1)'(TOTAL_PIXELS);

    logic [DATA_WIDTH-1:0] mem0 [TOTAL_PIXELS];
    logic [DATA_WIDTH-1:0] mem1 [TOTAL_PIXELS];

    state_t                state;
    state_t                next_state;
    logic                  rd_bank;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  handshake;
    logic                  final_beat;
    logic                  commit_accept;
    logic                  commit_reject;
    logic                  write_ok;

    assign handshake     = m_valid & m_ready;
    assign final_beat    = handshake & m_last;
    assign commit_accept = frame_tick & ((state == IDLE) | final_beat);
    assign commit_reject = frame_tick & ~commit_accept;
    assign write_ok      = we & ({1'b0, wAddr} < DEPTH);
    assign next_addr     = (rd_addr == LAST_ADDR) ? '0 : rd_addr + ADDR_WIDTH'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (commit_accept) next_state = PRIME;
            PRIME:   next_state = STREAM;
            STREAM:  if (final_beat) next_state = commit_accept ? PRIME : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        m_valid = (state == STREAM);
        busy    = (state != IDLE);
        m_last  = m_valid & (rd_addr == LAST_ADDR);
    end

    // Lookahead address: re-reading the current pixel during a stall keeps m_data stable.
    always_comb begin
        ram_addr = '0;
        if (state == STREAM) begin
            ram_addr = handshake ? next_addr : rd_addr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b1;
            rd_addr <= '0;
        end else begin
            if (commit_accept) begin
                rd_bank <= wr_bank;
                wr_bank <= ~wr_bank;
            end
            if (commit_accept) begin
                rd_addr <= '0;
            end else if (handshake) begin
                rd_addr <= next_addr;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_done <= 1'b0;
            frame_drop <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            frame_done <= final_beat;
            frame_drop <= commit_reject;
            if (commit_reject && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + DROP_CNT_WIDTH'(1);
            end
        end
    end

    // Frame storage is left unreset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (write_ok) begin
            if (wr_bank) begin
                mem1[wAddr] <= wData;
            end else begin
                mem0[wAddr] <= wData;
            end
        end
        rd_data <= rd_bank ? mem1[ram_addr] : mem0[ram_addr];
    end

    assign m_data = m_valid ? rd_data : '0;

endmodule

// File: tb/tb_tx_frame_buffer_pp.sv
// Scoreboard bench for tx_frame_buffer_pp using a 16-pixel frame; the address port is one
// bit wider than the depth needs so out-of-range writes can be expressed.
module tb_tx_frame_buffer_pp;

    localparam int DW  = 8;
    localparam int TP  = 16;
    localparam int AW  = 5;
    localparam int DCW = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           we;
    logic [DW-1:0]  wData;
    logic [AW-1:0]  wAddr;
    logic           frame_tick;
    logic           m_valid;
    logic           m_ready;
    logic [DW-1:0]  m_data;
    logic           m_last;
    logic           busy;
    logic           frame_done;
    logic           frame_drop;
    logic [DCW-1:0] drop_cnt;
    logic           wr_bank;

    int checks = 0;
    int errors = 0;
    int hs_count = 0;
    int done_count = 0;
    int exp_done = 0;
    int ready_mode = 0;
    logic [DW:0]   exp_q[$];
    logic          stalled = 1'b0;
    logic [DW-1:0] held_data = '0;

    tx_frame_buffer_pp #(
        .DATA_WIDTH(DW),
        .TOTAL_PIXELS(TP),
        .ADDR_WIDTH(AW),
        .DROP_CNT_WIDTH(DCW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .we(we),
        .wData(wData),
        .wAddr(wAddr),
        .frame_tick(frame_tick),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data(m_data),
        .m_last(m_last),
        .busy(busy),
        .frame_done(frame_done),
        .frame_drop(frame_drop),
        .drop_cnt(drop_cnt),
        .wr_bank(wr_bank)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock cycle of write/commit stimulus; returns 1ns after the edge.
    task automatic applyStimulus(input logic w, input int addr, input int data, input logic tick);
        we         = w;
        wAddr      = AW'(addr);
        wData      = DW'(data);
        frame_tick = tick;
        @(posedge clk);
        #1;
        we         = 1'b0;
        frame_tick = 1'b0;
    endtask

    task automatic fill_bank(input int base);
        for (int i = 0; i < TP; i++) applyStimulus(1'b1, i, base + i, 1'b0);
    endtask

    task automatic expect_frame(input int base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({(i == TP - 1), DW'(base + i)});
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (!frame_done && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        checkOutput(name, int'(frame_done), 1);
        checkOutput({name, "_busy"}, int'(busy), 0);
        checkOutput({name, "_valid"}, int'(m_valid), 0);
    endtask

    // Monitor: decides handshakes half a cycle ahead of the edge that takes them.
    always @(negedge clk) begin
        logic [DW:0] exp;
        done_count += int'(frame_done);
        if (m_valid && !reset) begin
            if (stalled) checkOutput("stall_hold", int'(m_data), int'(held_data));
            if (m_ready) begin
                hs_count++;
                stalled = 1'b0;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_beat", 1, 0);
                end else begin
                    exp = exp_q.pop_front();
                    checkOutput("beat_data", int'(m_data), int'(exp[DW-1:0]));
                    checkOutput("beat_last", int'(m_last), int'(exp[DW]));
                end
            end else begin
                stalled   = 1'b1;
                held_data = m_data;
            end
        end else begin
            stalled = 1'b0;
        end
    end

    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ~m_ready;
                default: m_ready = 1'b0;
            endcase
        end
    end

    initial begin
        int k;
        reset = 1'b0; we = 1'b0; wData = '0; wAddr = '0; frame_tick = 1'b0;
        #1 reset = 1'b1;
        #1;
        checkOutput("rst_valid", int'(m_valid), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_wr_bank", int'(wr_bank), 0);
        checkOutput("rst_drop_cnt", int'(drop_cnt), 0);
        checkOutput("rst_data", int'(m_data), 0);
        checkOutput("rst_last", int'(m_last), 0);
        checkOutput("rst_done", int'(frame_done), 0);
        checkOutput("rst_drop", int'(frame_drop), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        $display("[TB] basic stream, m_ready held high");
        fill_bank(8'h10);
        expect_frame(8'h10, TP);
        hs_count = 0;
        applyStimulus(1'b0, 0, 0, 1'b1);
        checkOutput("t1_wr_bank", int'(wr_bank), 1);
        checkOutput("t1_busy", int'(busy), 1);
        checkOutput("t1_prime_valid", int'(m_valid), 0);
        @(posedge clk); #1;
        checkOutput("t1_first_valid", int'(m_valid), 1);
        checkOutput("t1_first_data", int'(m_data), 8'h10);
        wait_done("t1_done");
        exp_done++;
        checkOutput("t1_beats", hs_count, TP);
        checkOutput("t1_queue", exp_q.size(), 0);
        @(posedge clk); #1;
        checkOutput("t1_done_count", done_count, exp_done);

        $display("[TB] stream with toggling m_ready");
        ready_mode = 1;
        fill_bank(8'h30);
        expect_frame(8'h30, TP);
        hs_count = 0;
        applyStimulus(1'b0, 0, 0, 1'b1);
        checkOutput("t2_wr_bank", int'(wr_bank), 0);
        wait_done("t2_done");
        exp_done++;
        checkOutput("t2_beats", hs_count, TP);
        checkOutput("t2_queue", exp_q.size(), 0);
        ready_mode = 0;

        $display("[TB] commit rejected mid-stream");
        fill_bank(8'h50);
        expect_frame(8'h50, TP);
        hs_count = 0;
        applyStimulus(1'b0, 0, 0, 1'b1);
        repeat (5) begin @(posedge clk); #1; end
        checkOutput("t3_busy", int'(busy), 1);
        applyStimulus(1'b0, 0, 0, 1'b1);
        checkOutput("t3_drop_pulse", int'(frame_drop), 1);
        checkOutput("t3_drop_cnt", int'(drop_cnt), 1);
        checkOutput("t3_wr_bank", int'(wr_bank), 1);
        @(posedge clk); #1;
        checkOutput("t3_drop_clear", int'(frame_drop), 0);
        wait_done("t3_done");
        exp_done++;
        checkOutput("t3_beats", hs_count, TP);

        $display("[TB] commit on the final handshake");
        fill_bank(8'h60);
        expect_frame(8'h60, TP);
        hs_count = 0;
        applyStimulus(1'b0, 0, 0, 1'b1);
        fill_bank(8'hA0);
        k = 0;
        while (!(m_valid && m_last) && k < 40) begin @(posedge clk); #1; k++; end
        checkOutput("t4_last_seen", int'(m_valid && m_last), 1);
        expect_frame(8'hA0, TP);
        applyStimulus(1'b0, 0, 0, 1'b1);
        checkOutput("t4_done_pulse", int'(frame_done), 1);
        checkOutput("t4_busy_held", int'(busy), 1);
        checkOutput("t4_gap_valid", int'(m_valid), 0);
        checkOutput("t4_no_drop", int'(frame_drop), 0);
        exp_done++;
        @(posedge clk); #1;
        checkOutput("t4_resume_valid", int'(m_valid), 1);
        checkOutput("t4_resume_data", int'(m_data), 8'hA0);
        checkOutput("t4_drop_cnt", int'(drop_cnt), 1);
        wait_done("t4_done");
        exp_done++;
        checkOutput("t4_beats", hs_count, 2 * TP);
        checkOutput("t4_queue", exp_q.size(), 0);

        $display("[TB] reset during pixel 7");
        fill_bank(8'hC0);
        expect_frame(8'hC0, 7);
        applyStimulus(1'b0, 0, 0, 1'b1);
        k = 0;
        while (!(m_valid && m_data == 8'hC7) && k < 40) begin @(posedge clk); #1; k++; end
        checkOutput("t5_pixel7_seen", int'(m_valid && m_data == 8'hC7), 1);
        #1 reset = 1'b1;
        #1;
        checkOutput("t5_valid", int'(m_valid), 0);
        checkOutput("t5_busy", int'(busy), 0);
        checkOutput("t5_data", int'(m_data), 0);
        checkOutput("t5_last", int'(m_last), 0);
        checkOutput("t5_wr_bank", int'(wr_bank), 0);
        checkOutput("t5_drop_cnt", int'(drop_cnt), 0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        checkOutput("t5_no_done", done_count, exp_done);
        checkOutput("t5_queue", exp_q.size(), 0);

        $display("[TB] out-of-range write and fresh stream");
        fill_bank(8'hE0);
        applyStimulus(1'b1, 16, 8'hFF, 1'b0);
        applyStimulus(1'b1, 31, 8'hEE, 1'b0);
        expect_frame(8'hE0, TP);
        hs_count = 0;
        applyStimulus(1'b0, 0, 0, 1'b1);
        wait_done("t6_done");
        exp_done++;
        checkOutput("t6_beats", hs_count, TP);
        checkOutput("t6_queue", exp_q.size(), 0);

        $display("[TB] drop counter saturation under a stalled stream");
        ready_mode = 2;
        expect_frame(8'hC0, TP);
        hs_count = 0;
        applyStimulus(1'b0, 0, 0, 1'b1);
        for (int i = 0; i < 254; i++) applyStimulus(1'b0, 0, 0, 1'b1);
        checkOutput("t6_drop_254", int'(drop_cnt), 254);
        for (int i = 0; i < 46; i++) applyStimulus(1'b0, 0, 0, 1'b1);
        checkOutput("t6_drop_sat", int'(drop_cnt), 255);
        checkOutput("t6_drop_pulse", int'(frame_drop), 1);
        checkOutput("t6_wr_bank", int'(wr_bank), 0);
        checkOutput("t6_stalled_beats", hs_count, 0);
        ready_mode = 0;
        wait_done("t6_sat_done");
        exp_done++;
        checkOutput("t6_sat_beats", hs_count, TP);
        checkOutput("t6_sat_queue", exp_q.size(), 0);
        checkOutput("t6_drop_final", int'(drop_cnt), 255);
        @(posedge clk); #1;
        checkOutput("final_done_count", done_count, exp_done);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
